ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
// - Shares one single-port RAM (RAM_DATA or RAM_S) between the instruction sub-FSMs (STP, EVP, EVB).
// - Each sub-FSM requests the RAM and is granted exclusive access; the arbiter muxes its address, data and enables onto the RAM.
// - Read data is routed back with a one-hot valid tag.
// - One instance per shared RAM, inside firing_state_FSM2.
// PARAMETERS
// - N_REQ      3     number of requesters (index 0 = STP, 1 = EVP, 2 = EVB)
// - word_size  16    RAM data width
// - addr_size  10    RAM address width
// - BURST_MAX  64    max consecutive owned cycles while another requester is pending
// PORTS
// - clk        in   1                  clock, rising edge
// - rst        in   1                  asynchronous reset, active-low
// - rst_instr  in   1                  synchronous flush, active-low (RST instruction)
// - req        in   N_REQ              request, held high for the whole access burst
// - rd_en      in   N_REQ              per-requester read strobe
// - wr_en      in   N_REQ              per-requester write strobe
// - addr       in   N_REQ*addr_size    flattened addresses; requester i uses [i*addr_size +: addr_size]
// - wdata      in   N_REQ*word_size    flattened write data, same packing as addr
// - gnt        out  N_REQ              registered one-hot grant
// - rvalid     out  N_REQ              one-hot; read data valid for that requester
// - rdata      out  word_size          read data = ram_q, passed through
// - ram_rd_en  out  1                  to RAM rd_en
// - ram_wr_en  out  1                  to RAM wr_en
// - ram_addr   out  addr_size          to RAM address
// - ram_wdata  out  word_size          to RAM data
// - ram_q      in   word_size          from RAM q; valid 1 cycle after ram_rd_en
// - err        out  1                  sticky; strobe seen without grant
// BEHAVIOUR
// - Reset (rst=0) and flush (rst_instr=0 at clk edge) both force:
//   - state=IDLE, gnt=0, rvalid=0, err=0, rr_ptr=0, burst_cnt=0.
//   - Flush takes priority over all other events in that cycle.
// - States: IDLE, OWN.
// - IDLE: if any req, the next edge grants the first set req searching from rr_ptr upward (mod N_REQ).
//   - State goes to OWN, owner=i, burst_cnt=0.
//   - Grant latency from IDLE is 1 cycle.
// - OWN, owner keeps req high: grant is held.
//   - burst_cnt increments each cycle.
//   - If burst_cnt==BURST_MAX-1 and another req is pending, the grant is forced to the next requester at that edge.
//   - Without other requests the burst is unlimited; burst_cnt saturates.
// - OWN, req[owner] drops: at that edge rr_ptr=owner+1 (mod N_REQ).
//   - If another req is pending it is granted directly (no idle cycle); otherwise state goes to IDLE and gnt=0.
// - RAM mux is combinational from the registered owner:
//   - ram_rd_en = rd_en[owner] & gnt[owner]; ram_wr_en = wr_en[owner] & gnt[owner].
//   - ram_addr / ram_wdata come from the owner slice; all zero when no grant.
// - Read and write in the same cycle: the write wins and ram_rd_en=0.
// - rvalid: registered, 1 cycle after ram_rd_en, one-hot on the requester that issued the read.
//   - This holds even if the grant moved on at that same edge.
// - Strobes from a non-granted requester are ignored and set err (sticky until rst / rst_instr).
// - Simultaneous req drop by the owner and a new req rising: the new requester is granted at that edge.
// STRUCTURE
// - Shared include poly_params.vh: STP/EVP/EVB requester indices, state encodings, and the log2 function already used by the firing FSMs.
// - Single module; the round-robin search is a function inside the module. No sub-module.
// TESTING
// - Reset: rst=0 mid-burst -> gnt=0, rvalid=0, err=0, all ram_* outputs 0 immediately (asynchronous).
// - Single read: req[1]=1 -> gnt=3'b010 next cycle; rd_en[1], addr=5, RAM[5]=16'h00A3
//   -> ram_addr=5 the same cycle; rvalid=3'b010, rdata=16'h00A3 the cycle after.
// - Round robin: req=3'b111 held; each owner drops req after 2 cycles
//   -> grant order 0,1,2 with no idle cycles between owners.
// - Starvation guard, BURST_MAX=4: STP holds req, EVB requests -> gnt moves to 3'b100 after 4 STP cycles.
// - Handover read: EVP reads then drops req in the same cycle, EVB is granted
//   -> rvalid=3'b010 one cycle later, not EVB.
// - Illegal access: wr_en[2]=1 while gnt=3'b001 -> ram_wr_en=0, err=1; rst_instr=0 pulse -> err=0, gnt=0.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: requester indices, arbiter states
// and width helpers shared by the firing FSM RAM arbiters.
package ram_port_arbiter_pkg;

  localparam int REQ_STP = 0;
  localparam int REQ_EVP = 1;
  localparam int REQ_EVB = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // ceil(log2(n)), never below 1 so a vector always exists
  function automatic int log2c(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin owner of one single-port RAM,
// bounded bursts under contention, one-hot read-valid return.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int word_size = 16,
  parameter int addr_size = 10,
  parameter int BURST_MAX = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rst_instr,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             rd_en,
  input  logic [N_REQ-1:0]             wr_en,
  input  logic [N_REQ*addr_size-1:0]   addr,
  input  logic [N_REQ*word_size-1:0]   wdata,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             rvalid,
  output logic [word_size-1:0]         rdata,
  output logic                         ram_rd_en,
  output logic                         ram_wr_en,
  output logic [addr_size-1:0]         ram_addr,
  output logic [word_size-1:0]         ram_wdata,
  input  logic [word_size-1:0]         ram_q,
  output logic                         err
);

  localparam int IW = log2c(N_REQ);
  localparam int CW = log2c(BURST_MAX);

  typedef logic [IW-1:0]    idx_t;
  typedef logic [CW-1:0]    cnt_t;
  typedef logic [N_REQ-1:0] vec_t;

  localparam cnt_t CNT_MAX = cnt_t'(BURST_MAX - 1);
  localparam vec_t ONE     = vec_t'(1);

  function automatic vec_t oh(input idx_t i);
    return ONE << i;
  endfunction

  function automatic idx_t inc(input idx_t i);
    return (int'(i) == N_REQ - 1) ? '0 : idx_t'(int'(i) + 1);
  endfunction

  // first set bit of v at or after start, wrapping
  function automatic idx_t rr_pick(
    input vec_t v,
    input idx_t start
  );
    vec_t rot;
    idx_t pk;
    int   p;
    rot = (v >> start) | (v << (N_REQ - int'(start)));
    pk  = start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        p = int'(start) + k;
        if (p >= N_REQ) p = p - N_REQ;
        pk = idx_t'(p);
      end
    end
    return pk;
  endfunction

  arb_state_t state_q, state_d;
  idx_t       owner_q, owner_d;
  idx_t       rr_q, rr_d;
  idx_t       pick;
  cnt_t       cnt_q, cnt_d;
  vec_t       gnt_q, gnt_d;
  vec_t       rvalid_q, rvalid_d;
  vec_t       others, strobe;
  logic       err_q, err_d;
  logic       drop, preempt, hold;

  // RAM mux driven straight from the registered one-hot grant
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) begin
        ram_addr  = addr[i*addr_size +: addr_size];
        ram_wdata = wdata[i*word_size +: word_size];
      end
    end
  end

  assign ram_wr_en = |(wr_en & gnt_q);
  assign ram_rd_en = |(rd_en & gnt_q) & ~ram_wr_en;

  // ownership: idle grant, hold, preempt, or direct handover
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    others  = req & ~oh(owner_q);
    drop    = ~req[owner_q];
    preempt = ~drop & (cnt_q == CNT_MAX) & (|others);
    hold    = ~drop & ~preempt;
    pick    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          pick    = rr_pick(req, rr_q);
          state_d = ST_OWN;
          owner_d = pick;
          gnt_d   = oh(pick);
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        pick = rr_pick(others, inc(owner_q));
        unique case (1'b1)
          drop: begin
            rr_d  = inc(owner_q);
            cnt_d = '0;
            if (|others) begin
              owner_d = pick;
              gnt_d   = oh(pick);
            end else begin
              state_d = ST_IDLE;
              gnt_d   = '0;
            end
          end
          preempt: begin
            rr_d    = inc(owner_q);
            owner_d = pick;
            gnt_d   = oh(pick);
            cnt_d   = '0;
          end
          hold: begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    if (!rst_instr) begin
      state_d = ST_IDLE;
      owner_d = '0;
      rr_d    = '0;
      cnt_d   = '0;
      gnt_d   = '0;
    end
  end

  // read tag follows the issuing requester, not the next owner
  always_comb begin
    strobe   = rd_en | wr_en;
    rvalid_d = ram_rd_en ? gnt_q : '0;
    err_d    = err_q | (|(strobe & ~gnt_q));
    if (!rst_instr) begin
      rvalid_d = '0;
      err_d    = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level ownership model.
module tb_ram_port_arbiter;

  localparam int NR = 3;
  localparam int WS = 16;
  localparam int AS = 10;
  localparam int BM = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            rst_instr;
  logic [NR-1:0]   req, rd_en, wr_en;
  logic [NR*AS-1:0] addr;
  logic [NR*WS-1:0] wdata;
  logic [NR-1:0]   gnt, rvalid;
  logic [WS-1:0]   rdata;
  logic            ram_rd_en, ram_wr_en;
  logic [AS-1:0]   ram_addr;
  logic [WS-1:0]   ram_wdata;
  logic [WS-1:0]   ram_q;
  logic            err;

  logic [WS-1:0]   mem     [0:1023];
  logic [WS-1:0]   ref_mem [0:1023];

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(
    .N_REQ(NR), .word_size(WS),
    .addr_size(AS), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .rst(rst), .rst_instr(rst_instr),
    .req(req), .rd_en(rd_en), .wr_en(wr_en),
    .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_q(ram_q), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) ram_q <= mem[ram_addr];
    if (ram_wr_en) mem[ram_addr] = ram_wdata;
  end

  task automatic clr_in();
    req = '0; rd_en = '0; wr_en = '0;
    addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_instr = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int pick(input logic [NR-1:0] r,
                              input int start);
    for (int k = 0; k < NR; k++) begin
      if (r[(start + k) % NR]) return (start + k) % NR;
    end
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (gnt !== 3'b000 || err !== 1'b0 || rvalid !== 3'b000) begin
      errors++;
      $display("FAIL reset_state gnt=%b err=%b rv=%b exp 000/0/000",
               gnt, err, rvalid);
    end
    req = 3'b001;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001) begin
      errors++; $display("FAIL rst_gnt got %b exp 001", gnt);
    end
    rd_en = 3'b001; addr[9:0] = 10'd7; wr_en = 3'b010;
    #1;
    checks++;
    if (ram_rd_en !== 1'b1 || ram_addr !== 10'd7) begin
      errors++;
      $display("FAIL rst_rd rd=%b a=%0d exp 1/7", ram_rd_en, ram_addr);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 3'b001 || err !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre rv=%b err=%b exp 001/1", rvalid, err);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 3'b000 || rvalid !== 3'b000 || err !== 1'b0 ||
        ram_rd_en !== 1'b0 || ram_wr_en !== 1'b0 ||
        ram_addr !== 10'd0 || ram_wdata !== 16'd0) begin
      errors++;
      $display("FAIL async_rst gnt=%b rv=%b err=%b rd=%b wr=%b a=%0d exp all 0",
               gnt, rvalid, err, ram_rd_en, ram_wr_en, ram_addr);
    end
    @(negedge clk);
    clr_in();
    rst = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    mem[5] = 16'h00A3;
    req = 3'b010;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b010) begin
      errors++; $display("FAIL rd_gnt got %b exp 010", gnt);
    end
    rd_en = 3'b010; addr[19:10] = 10'd5;
    #1;
    checks++;
    if (ram_addr !== 10'd5 || ram_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL rd_addr a=%0d rd=%b exp 5/1", ram_addr, ram_rd_en);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 3'b010 || rdata !== 16'h00A3) begin
      errors++;
      $display("FAIL rd_data rv=%b d=%h exp 010/00a3", rvalid, rdata);
    end
    wr_en = 3'b010; wdata[31:16] = 16'hBEEF;
    #1;
    checks++;
    if (ram_rd_en !== 1'b0 || ram_wr_en !== 1'b1 ||
        ram_wdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL rw_coll rd=%b wr=%b wd=%h exp 0/1/beef",
               ram_rd_en, ram_wr_en, ram_wdata);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 3'b000) begin
      errors++; $display("FAIL rw_rvalid got %b exp 000", rvalid);
    end
    wr_en = 3'b000;
    @(negedge clk);
    checks++;
    if (rvalid !== 3'b010 || rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL rd_back rv=%b d=%h exp 010/beef", rvalid, rdata);
    end
    clr_in();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp;
    do_reset();
    req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp = 3'b001 << (c / 2);
      checks++;
      if (gnt !== exp) begin
        errors++;
        $display("FAIL rr_gnt%0d got %b exp %b", c, gnt, exp);
      end
      if (c % 2 == 1) req[c/2] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (gnt !== 3'b000) begin
      errors++; $display("FAIL rr_idle got %b exp 000", gnt);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    req = 3'b101;
    for (int c = 0; c < BM; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 3'b001) begin
        errors++; $display("FAIL sv_hold%0d got %b exp 001", c, gnt);
      end
    end
    @(negedge clk);
    checks++;
    if (gnt !== 3'b100) begin
      errors++; $display("FAIL sv_move got %b exp 100", gnt);
    end
    do_reset();
    req = 3'b001;
    for (int c = 0; c < 2 * BM; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 3'b001) begin
        errors++; $display("FAIL sat_hold%0d got %b exp 001", c, gnt);
      end
    end
    req = 3'b101;
    @(negedge clk);
    checks++;
    if (gnt !== 3'b100) begin
      errors++; $display("FAIL sat_move got %b exp 100", gnt);
    end
    clr_in();
  endtask

  task automatic test_handover();
    do_reset();
    mem[9] = 16'h5A5A;
    req = 3'b010;
    @(negedge clk);
    rd_en = 3'b010; addr[19:10] = 10'd9; req = 3'b100;
    #1;
    checks++;
    if (gnt !== 3'b010 || ram_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL ho_rd gnt=%b rd=%b exp 010/1", gnt, ram_rd_en);
    end
    @(negedge clk);
    rd_en = 3'b000;
    checks++;
    if (gnt !== 3'b100 || rvalid !== 3'b010 ||
        rdata !== 16'h5A5A || err !== 1'b0) begin
      errors++;
      $display("FAIL ho_tag gnt=%b rv=%b d=%h err=%b exp 100/010/5a5a/0",
               gnt, rvalid, rdata, err);
    end
    clr_in();
  endtask

  task automatic test_illegal();
    do_reset();
    req = 3'b001;
    @(negedge clk);
    wr_en = 3'b100; addr[29:20] = 10'd3;
    #1;
    checks++;
    if (ram_wr_en !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL ill_wr wr=%b err=%b exp 0/0", ram_wr_en, err);
    end
    @(negedge clk);
    wr_en = 3'b000;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL ill_err got %b exp 1", err);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL ill_sticky got %b exp 1", err);
    end
    rst_instr = 1'b0;
    @(negedge clk);
    rst_instr = 1'b1;
    checks++;
    if (gnt !== 3'b000 || err !== 1'b0) begin
      errors++;
      $display("FAIL flush gnt=%b err=%b exp 000/0", gnt, err);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 3'b001) begin
      errors++; $display("FAIL post_flush got %b exp 001", gnt);
    end
    clr_in();
  endtask

  task automatic test_random();
    int own, rr, ten, b;
    logic [NR-1:0] e_gnt, e_rv, oth;
    logic          e_err, e_wr, e_rdn;
    logic [AS-1:0] e_a;
    logic [WS-1:0] e_wd, e_rd;
    do_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    own = -1; rr = 0; ten = 0;
    e_err = 1'b0; e_rv = '0; e_rd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 5) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
        addr[i*AS +: AS]  = AS'($urandom_range(0, 15));
        wdata[i*WS +: WS] = WS'($urandom);
      end
      rd_en = '0; wr_en = '0;
      if (own >= 0) begin
        rd_en[own] = 1'($urandom_range(0, 1));
        wr_en[own] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 49) == 0) begin
        b = $urandom_range(0, NR - 1);
        rd_en[b] = 1'b1;
      end
      rst_instr = ($urandom_range(0, 149) != 0);
      #1;
      e_gnt = (own >= 0) ? NR'(1 << own) : '0;
      e_wr = 1'b0; e_rdn = 1'b0; e_a = '0; e_wd = '0;
      if (own >= 0) begin
        e_wr  = wr_en[own];
        e_rdn = rd_en[own] & ~wr_en[own];
        e_a   = addr[own*AS +: AS];
        e_wd  = wdata[own*WS +: WS];
      end
      checks++;
      if (gnt !== e_gnt) begin
        errors++;
        $display("FAIL rnd_gnt c%0d got %b exp %b", cyc, gnt, e_gnt);
      end
      checks++;
      if (rvalid !== e_rv) begin
        errors++;
        $display("FAIL rnd_rv c%0d got %b exp %b", cyc, rvalid, e_rv);
      end
      checks++;
      if (err !== e_err) begin
        errors++;
        $display("FAIL rnd_err c%0d got %b exp %b", cyc, err, e_err);
      end
      checks++;
      if (ram_rd_en !== e_rdn || ram_wr_en !== e_wr) begin
        errors++;
        $display("FAIL rnd_en c%0d rd=%b wr=%b exp %b/%b",
                 cyc, ram_rd_en, ram_wr_en, e_rdn, e_wr);
      end
      checks++;
      if (ram_addr !== e_a || ram_wdata !== e_wd) begin
        errors++;
        $display("FAIL rnd_bus c%0d a=%0d wd=%h exp %0d/%h",
                 cyc, ram_addr, ram_wdata, e_a, e_wd);
      end
      if (e_rv != '0) begin
        checks++;
        if (rdata !== e_rd) begin
          errors++;
          $display("FAIL rnd_rdata c%0d got %h exp %h", cyc, rdata, e_rd);
        end
      end
      @(posedge clk);
      if (e_rdn) e_rd = ref_mem[e_a];
      if (e_wr) ref_mem[e_a] = e_wd;
      if (!rst_instr) begin
        own = -1; rr = 0; ten = 0;
        e_err = 1'b0; e_rv = '0;
      end else begin
        if (|((rd_en | wr_en) & ~e_gnt)) e_err = 1'b1;
        e_rv = e_rdn ? e_gnt : '0;
        oth = req & ~e_gnt;
        if (own < 0) begin
          if (req != '0) begin
            own = pick(req, rr); ten = 1;
          end
        end else if (!req[own]) begin
          rr = (own + 1) % NR;
          own = pick(req, rr); ten = 1;
        end else if (ten >= BM && oth != '0) begin
          rr = (own + 1) % NR;
          own = pick(oth, rr); ten = 1;
        end else begin
          ten++;
        end
      end
      @(negedge clk);
    end
    clr_in();
    rst_instr = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    rst_instr = 1'b1;
    clr_in();
    for (int i = 0; i < 1024; i++) mem[i] = WS'(i * 37 + 5);
    test_reset();
    test_single_read();
    test_round_robin();
    test_starvation();
    test_handover();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
